// File: rtl/seg7_scanner.sv
// seg7_scanner: 8-digit common-anode 7-seg scanner with
// per-slot ghost blanking and frame-synchronous shadow buffers.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   segment_cs_n   active-low enable (sync to clk)
//   value[31:0]    eight hex nibbles, digit i = value[4i+3:4i]
//   dp[7:0]        decimal point per digit, 1 = lit
//   digit_en[7:0]  per-digit enable, 0 = blank
//   an_n[7:0]      anodes, active-low, bit i = digit i
//   seg_n[6:0]     cathodes {g,f,e,d,c,b,a}, active-low
//   dp_n           decimal-point cathode, active-low
//   frame_done     one-cycle pulse per completed frame
module seg7_scanner #(
  parameter int unsigned DIGIT_TICKS = 28000,
  parameter int unsigned BLANK_TICKS = 1400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        segment_cs_n,
  input  logic [31:0] value,
  input  logic [7:0]  dp,
  input  logic [7:0]  digit_en,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int CW =
    (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_C =
    CW'(BLANK_TICKS);

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          run_q, run_d;
  logic [31:0]   val_q, val_d;
  logic [7:0]    dp_q, dp_d;
  logic [7:0]    en_q, en_d;

  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dpo_q, dpo_d;
  logic          fd_q, fd_d;

  logic          in_blank;
  logic          lit;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(
    input logic [3:0] n
  );
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Deselect has priority over start and over the
  // frame wrap, so a partial frame never reloads or
  // reports completion.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    run_d = run_q;
    val_d = val_q;
    dp_d  = dp_q;
    en_d  = en_q;
    fd_d  = 1'b0;
    if (segment_cs_n) begin
      cnt_d = '0;
      idx_d = '0;
      run_d = 1'b0;
    end else if (!run_q) begin
      cnt_d = '0;
      idx_d = '0;
      run_d = 1'b1;
      val_d = value;
      dp_d  = dp;
      en_d  = digit_en;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        val_d = value;
        dp_d  = dp;
        en_d  = digit_en;
        fd_d  = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  generate
    if (BLANK_TICKS == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_q < BLANK_C);
    end
  endgenerate

  assign nib = val_q[{idx_q, 2'b00} +: 4];
  assign lit = run_q && !in_blank && en_q[idx_q];

  // Outputs come from a single registered decode of
  // the current slot, so only one anode can be low.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dpo_d = 1'b1;
    if (lit) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = hex7(nib);
      dpo_d = ~dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
      val_q <= '0;
      dp_q  <= '0;
      en_q  <= '0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dpo_q <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      run_q <= run_d;
      val_q <= val_d;
      dp_q  <= dp_d;
      en_q  <= en_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dpo_q <= dpo_d;
      fd_q  <= fd_d;
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dp_n       = dpo_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: scoreboard bench for seg7_scanner
// with a frame-position reference model.
module tb_seg7_scanner;

  localparam int DT = 8;
  localparam int BT = 2;
  localparam int FR = 8 * DT;
  localparam logic [16:0] OFF =
    {8'hFF, 7'h7F, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic [31:0] value;
  logic [7:0]  dp;
  logic [7:0]  en;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scanner #(
    .DIGIT_TICKS(DT),
    .BLANK_TICKS(BT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .segment_cs_n(cs_n),
    .value       (value),
    .dp          (dp),
    .digit_en    (en),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_done  (frame_done)
  );

  int tests = 0;
  int fails = 0;
  logic [16:0] exp_q[$];

  bit          m_run;
  int          m_p;
  logic [31:0] m_val;
  logic [7:0]  m_dp;
  logic [7:0]  m_en;
  logic [16:0] m_e;
  int          m_dig;
  int          m_off;
  bit          m_fd;

  function automatic logic [6:0] hexseg(
    input logic [3:0] n
  );
    logic [6:0] t [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // m_p is the clock position within the frame since
  // the last start; digit = p/DT, offset = p%DT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0;
      m_p   = 0;
      if (exp_q.size() == 0)
        exp_q.push_back(OFF);
      else
        exp_q[exp_q.size()-1] = OFF;
    end else begin
      m_dig = m_p / DT;
      m_off = m_p % DT;
      if (m_run && m_off >= BT && m_en[m_dig])
        m_e = {~(8'b1 << m_dig),
               hexseg(m_val[m_dig*4 +: 4]),
               ~m_dp[m_dig], 1'b0};
      else
        m_e = OFF;
      m_fd = 1'b0;
      if (cs_n) begin
        m_run = 1'b0;
        m_p   = 0;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_p   = 0;
        m_val = value;
        m_dp  = dp;
        m_en  = en;
      end else begin
        m_p++;
        if (m_p == FR) begin
          m_p   = 0;
          m_val = value;
          m_dp  = dp;
          m_en  = en;
          m_fd  = 1'b1;
        end
      end
      m_e[0] = m_fd;
      exp_q.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    logic [16:0] a;
    a = {an_n, seg_n, dp_n, frame_done};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (a !== e) begin
        fails++;
        $display(
          "FAIL scoreboard t=%0t got an_n=%h seg_n=%h dp_n=%b fd=%b want an_n=%h seg_n=%h dp_n=%b fd=%b",
          $time, a[16:9], a[8:2], a[1], a[0],
          e[16:9], e[8:2], e[1], e[0]);
      end
    end
    tests++;
    if ($countones(~an_n) > 1) begin
      fails++;
      $display("FAIL onehot t=%0t an_n=%h want <=1 zero",
               $time, an_n);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cs_n  = 1'b1;
    value = '0;
    dp    = '0;
    en    = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);

    value = 32'h76543210;
    dp    = 8'h01;
    en    = 8'hFF;
    cs_n  = 1'b0;
    cyc(2 * FR + 20);

    rst_n = 1'b0;
    cyc(3);
    cs_n  = 1'b1;
    rst_n = 1'b1;
    cyc(100);

    cs_n = 1'b0;
    cyc(FR + 3 * DT + 4);
    value = 32'hFEDCBA98;
    cyc(2 * FR);

    en = 8'h0F;
    cyc(2 * FR);

    en   = 8'hFF;
    cs_n = 1'b1;
    cyc(5);
    cs_n = 1'b0;
    cyc(FR + 5 * DT + 4);
    cs_n = 1'b1;
    cyc(10);
    cs_n = 1'b0;
    cyc(30);

    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(20);

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 149) == 0)
        cs_n = ~cs_n;
      if ($urandom_range(0, 15) == 0) begin
        value = $urandom;
        dp    = 8'($urandom);
        en    = 8'($urandom);
      end
      cyc(1);
    end

    cs_n = 1'b1;
    cyc(4);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scanner.md
# seg7_scanner

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display, downstream of the status chip-select decode. It is enabled by the active-low `segment_cs_n` select and scans eight hex nibbles onto the shared cathode bus. It inserts a ghost-suppression blank at the start of each digit slot. Display data is double-buffered so that a value changes only on a frame boundary.

## Interface
Parameters:
- `DIGIT_TICKS`, default 28000: clocks per digit slot. Must be ≥ 2.
- `BLANK_TICKS`, default 1400: clocks at the start of each slot with all anodes off. Must be ≥ 0 and < `DIGIT_TICKS`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `segment_cs_n`  in  1  active-low enable; synchronous to `clk`.
- `value`  in  32  eight hex nibbles; digit i = `value[4i+3:4i]`.
- `dp`  in  8  decimal point per digit, 1 = lit.
- `digit_en`  in  8  per-digit enable, 0 = blank that digit.
- `an_n`  out  8  anode drives, active-low; bit i = digit i.
- `seg_n`  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- `dp_n`  out  1  decimal-point cathode, active-low.
- `frame_done`  out  1  one-cycle pulse at the end of each completed frame.

## Operation
- State:
  - slot counter `cnt`, range 0..DIGIT_TICKS-1;
  - digit index `idx`, range 0..7;
  - shadow registers for `value`, `dp` and `digit_en`;
  - a running flag.
- Idle (`segment_cs_n`=1):
  - `cnt`=0, `idx`=0, running=0;
  - outputs are at their off values: `an_n`=8'hFF, `seg_n`=7'h7F, `dp_n`=1, `frame_done`=0.
- Start: on the first cycle with `segment_cs_n`=0 and running=0:
  - the shadows load from the inputs;
  - running sets;
  - `cnt`=0 and `idx`=0.
- Run: each cycle `cnt` increments. When `cnt`=DIGIT_TICKS-1:
  - `cnt` goes to 0 and `idx` increments, wrapping 7→0;
  - if `idx` was 7, the shadows reload from the inputs and `frame_done` pulses.
- Deselect mid-frame: `segment_cs_n`=1 returns the block to Idle on the next clock edge. The partial frame produces no `frame_done`.
- Output function, computed from the current state and registered:
  - While `cnt` < BLANK_TICKS, or when `shadow_digit_en[idx]`=0: all outputs are off.
  - Otherwise: `an_n` = ~(1<<idx), `seg_n` = decode(shadow nibble `idx`), `dp_n` = ~`shadow_dp[idx]`.
- Hex decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78;
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Input changes mid-frame have no visible effect until the next frame boundary.
- At most one anode is low at any time, including across slot transitions.

## Timing
- Reset (`rst_n`=0, asynchronous): `an_n`=8'hFF, `seg_n`=7'h7F, `dp_n`=1, `frame_done`=0, all counters and shadows 0, running=0.
- All outputs are registered, so each output lags the state it reflects by 1 clock.
- Start latency: with `segment_cs_n` sampled low at edge E0, the first anode goes low at edge E0+BLANK_TICKS+1.
  - Example: BLANK_TICKS=0 gives E0+1.
- Digit slot: exactly DIGIT_TICKS clocks. Anode-low time per slot is DIGIT_TICKS-BLANK_TICKS clocks.
- Frame: 8×DIGIT_TICKS clocks. `frame_done` is high for exactly 1 clock per frame.
- Stop latency: when `segment_cs_n` is sampled high at edge E, the outputs are off from edge E+1.
- Simultaneous wrap and deselect: deselect wins. No shadow reload and no `frame_done`.
- Release of `rst_n` while `segment_cs_n`=0: Start occurs on the first clock after release.

## Test plan
Bench parameters: DIGIT_TICKS=8, BLANK_TICKS=2.

1. Reset and idle.
   - Stimulus: assert `rst_n`=0 mid-scan; then hold `segment_cs_n`=1 for 100 clocks.
   - Required response: `an_n`=FF, `seg_n`=7F, `dp_n`=1 and `frame_done`=0 immediately, and throughout the idle period.
2. Scan order and decode.
   - Stimulus: `value`=32'h76543210, `dp`=8'h01, `digit_en`=FF, `segment_cs_n`=0.
   - Required response:
     - digit 0: `an_n`=FE, `seg_n`=40, `dp_n`=0;
     - digit 1: `an_n`=FD, `seg_n`=79;
     - continuing in order through digit 7: `an_n`=7F, `seg_n`=78.
     - Each digit is lit for 6 clocks after 2 blank clocks. `frame_done` pulses every 64 clocks.
3. Double buffering.
   - Stimulus: change `value` to 32'hFEDCBA98 while digit 3 is lit.
   - Required response: digits 4–7 still show 4,5,6,7. From the next frame, digit 0 shows 8 (`seg_n`=00) and digit 7 shows F (`seg_n`=0E).
4. Digit enable mask.
   - Stimulus: `digit_en`=8'h0F.
   - Required response: `an_n` never has bits 7:4 low. Slots 4–7 keep their timing but hold all outputs off.
5. Deselect mid-frame.
   - Stimulus: raise `segment_cs_n` during digit 5.
   - Required response: outputs are off 1 clock later and `frame_done` does not pulse. After reselect, the first anode low is `an_n`=FE, 3 clocks after the select is sampled.
6. One-hot invariant.
   - Stimulus: random `value`, `dp`, `digit_en` and `segment_cs_n` toggling for 10k clocks.
   - Required response: the number of zero bits in `an_n` is never greater than 1.
